// File: rtl/dart_pkg.sv
// Shared constants, FSM encoding and dart scoring helper
// for the two-player dart game controller.
package dart_pkg;

    localparam int START_PT       = 301;
    localparam int DARTS_PER_TURN = 3;
    localparam int BULL           = 25;
    localparam int SCORE_W        = 7;
    localparam int PT_W           = 9;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        APPLY,
        OVER
    } state_t;

    // Legal segments are 1..20 with any multiplier, or bull single/double.
    function automatic logic hit_ok(
        input logic [4:0] base,
        input logic [1:0] mult
    );
        return (mult != 2'd0) &&
               ((base <= 5'd20) ||
                (base == 5'(BULL) && mult != 2'd3));
    endfunction

endpackage

// File: rtl/dart_hit_value.sv
// Holds the latched dart and registers its checked score
// (base*mult, or 0 for an illegal dart).
module dart_hit_value
    import dart_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               calc_i,
    input  logic [4:0]         base_i,
    input  logic [1:0]         mult_i,
    output logic [SCORE_W-1:0] score_o
);

    logic [4:0]         base_q;
    logic [1:0]         mult_q;
    logic [SCORE_W-1:0] prod;
    logic               valid;

    always_comb begin
        valid = hit_ok(base_q, mult_q);
        prod  = SCORE_W'(base_q) * SCORE_W'(mult_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q  <= '0;
            mult_q  <= '0;
            score_o <= '0;
        end else begin
            if (load_i) begin
                base_q <= base_i;
                mult_q <= mult_i;
            end
            if (calc_i) begin
                score_o <= valid ? prod : '0;
            end
        end
    end

endmodule

// File: rtl/dart_game_ctrl.sv
// Two-player countdown dart game: latches a hit, scores it,
// then applies it to the active player's points.
module dart_game_ctrl #(
    parameter int START_PT       = dart_pkg::START_PT,
    parameter int DARTS_PER_TURN = dart_pkg::DARTS_PER_TURN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hit_valid_i,
    input  logic [4:0] hit_base_i,
    input  logic [1:0] hit_mult_i,
    output logic       busy_o,
    output logic       player_1_done_o,
    output logic       player_2_done_o,
    output logic       player_1_win_o,
    output logic       player_2_win_o,
    output logic [8:0] player_1_pt_o,
    output logic [8:0] player_2_pt_o,
    output logic       game_set_o
);

    import dart_pkg::*;

    state_t             state;
    state_t             state_nx;
    logic               act;
    logic               oth;
    logic [CNT_W-1:0]   cnt;
    logic [PT_W-1:0]    pts   [2];
    logic [PT_W-1:0]    start [2];
    logic [1:0]         done_q;
    logic [1:0]         win_q;
    logic               set_q;
    logic [SCORE_W-1:0] score;
    logic [PT_W-1:0]    rem;
    logic [PT_W-1:0]    score_w;
    logic               hit_win;
    logic               hit_bust;
    logic               last_dart;
    logic               load;
    logic               calc;

    assign load = (state == IDLE) && hit_valid_i;
    assign calc = (state == CALC);

    dart_hit_value u_hit (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .calc_i  (calc),
        .base_i  (hit_base_i),
        .mult_i  (hit_mult_i),
        .score_o (score)
    );

    always_comb begin
        oth       = ~act;
        rem       = pts[act];
        score_w   = PT_W'(score);
        hit_win   = (score_w == rem);
        hit_bust  = (score_w > rem);
        last_dart = (cnt == CNT_W'(DARTS_PER_TURN - 1));
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (hit_valid_i) state_nx = CALC;
            CALC:    state_nx = APPLY;
            APPLY:   state_nx = hit_win ? OVER : IDLE;
            OVER:    state_nx = OVER;
            default: state_nx = IDLE;
        endcase
    end

    // A bust or the last dart hands over; the next player's
    // current points become their turn-start value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            act      <= 1'b0;
            cnt      <= '0;
            pts[0]   <= PT_W'(START_PT);
            pts[1]   <= PT_W'(START_PT);
            start[0] <= PT_W'(START_PT);
            start[1] <= PT_W'(START_PT);
            done_q   <= '0;
            win_q    <= '0;
            set_q    <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= '0;
            if (state == APPLY) begin
                done_q[act] <= 1'b1;
                if (hit_win) begin
                    pts[act]   <= '0;
                    win_q[act] <= 1'b1;
                    set_q      <= 1'b1;
                end else if (hit_bust) begin
                    pts[act]   <= start[act];
                    act        <= oth;
                    cnt        <= '0;
                    start[oth] <= pts[oth];
                end else begin
                    pts[act] <= rem - score_w;
                    if (last_dart) begin
                        act        <= oth;
                        cnt        <= '0;
                        start[oth] <= pts[oth];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign busy_o          = (state == CALC) || (state == APPLY);
    assign player_1_done_o = done_q[0];
    assign player_2_done_o = done_q[1];
    assign player_1_win_o  = win_q[0];
    assign player_2_win_o  = win_q[1];
    assign player_1_pt_o   = pts[0];
    assign player_2_pt_o   = pts[1];
    assign game_set_o      = set_q;

endmodule

// File: tb/tb_dart_game_ctrl.sv
// Self-checking bench for dart_game_ctrl: directed scenarios
// plus random games against a rule-level reference model.
module tb_dart_game_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       hit_valid_i;
    logic [4:0] hit_base_i;
    logic [1:0] hit_mult_i;
    logic       busy_o;
    logic       player_1_done_o;
    logic       player_2_done_o;
    logic       player_1_win_o;
    logic       player_2_win_o;
    logic [8:0] player_1_pt_o;
    logic [8:0] player_2_pt_o;
    logic       game_set_o;

    int total = 0;
    int bad   = 0;

    int m_pts   [2];
    int m_start [2];
    int m_act;
    int m_darts;
    bit m_win   [2];
    bit m_over;

    dart_game_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .hit_valid_i     (hit_valid_i),
        .hit_base_i      (hit_base_i),
        .hit_mult_i      (hit_mult_i),
        .busy_o          (busy_o),
        .player_1_done_o (player_1_done_o),
        .player_2_done_o (player_2_done_o),
        .player_1_win_o  (player_1_win_o),
        .player_2_win_o  (player_2_win_o),
        .player_1_pt_o   (player_1_pt_o),
        .player_2_pt_o   (player_2_pt_o),
        .game_set_o      (game_set_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int dart_score(input int b, input int m);
        if (m >= 1 && m <= 3 && b >= 0 && b <= 20) return b * m;
        if (b == 25 && (m == 1 || m == 2)) return b * m;
        return 0;
    endfunction

    task automatic model_reset();
        m_pts   = '{301, 301};
        m_start = '{301, 301};
        m_win   = '{1'b0, 1'b0};
        m_act   = 0;
        m_darts = 0;
        m_over  = 1'b0;
    endtask

    task automatic model_apply(input int b, input int m);
        int s;
        s = dart_score(b, m);
        if (m_over) return;
        if (s == m_pts[m_act]) begin
            m_pts[m_act] = 0;
            m_win[m_act] = 1'b1;
            m_over = 1'b1;
        end else if (s > m_pts[m_act]) begin
            m_pts[m_act] = m_start[m_act];
            m_act = 1 - m_act;
            m_darts = 0;
            m_start[m_act] = m_pts[m_act];
        end else begin
            m_pts[m_act] -= s;
            m_darts++;
            if (m_darts == 3) begin
                m_act = 1 - m_act;
                m_darts = 0;
                m_start[m_act] = m_pts[m_act];
            end
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_p1pt"}, 32'(player_1_pt_o), 32'(m_pts[0]));
        chk({tag, "_p2pt"}, 32'(player_2_pt_o), 32'(m_pts[1]));
        chk({tag, "_win1"}, 32'(player_1_win_o), 32'(m_win[0]));
        chk({tag, "_win2"}, 32'(player_2_win_o), 32'(m_win[1]));
        chk({tag, "_set"}, 32'(game_set_o), 32'(m_over));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        hit_valid_i = 1'b0;
        @(negedge clk);
        model_reset();
        chk_state("rst");
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'({player_1_done_o, player_2_done_o}), 0);
        reset = 1'b0;
    endtask

    // One dart: pulse at N, optional stray pulse at N+1, result at N+2.
    task automatic dart(input int b, input int m, input bit dbl);
        bit over0;
        int who;
        over0 = m_over;
        who   = m_act;
        @(negedge clk);
        hit_valid_i = 1'b1;
        hit_base_i  = 5'(b);
        hit_mult_i  = 2'(m);
        @(negedge clk);
        hit_valid_i = dbl;
        chk("calc_busy", 32'(busy_o), 32'(!over0));
        chk("calc_done", 32'({player_1_done_o, player_2_done_o}), 0);
        @(negedge clk);
        hit_valid_i = 1'b0;
        chk("apply_busy", 32'(busy_o), 32'(!over0));
        chk("apply_done", 32'({player_1_done_o, player_2_done_o}), 0);
        @(negedge clk);
        model_apply(b, m);
        chk("done1", 32'(player_1_done_o), 32'(!over0 && who == 0));
        chk("done2", 32'(player_2_done_o), 32'(!over0 && who == 1));
        chk("post_busy", 32'(busy_o), 0);
        chk_state("dart");
        @(negedge clk);
        chk("after_done", 32'({player_1_done_o, player_2_done_o}), 0);
        chk("after_busy", 32'(busy_o), 0);
    endtask

    initial begin
        reset       = 1'b1;
        hit_valid_i = 1'b0;
        hit_base_i  = '0;
        hit_mult_i  = '0;
        model_reset();

        do_reset();
        dart(20, 3, 0);
        chk("s1_p1", 32'(player_1_pt_o), 241);
        chk("s1_p2", 32'(player_2_pt_o), 301);

        do_reset();
        dart(20, 1, 0);
        dart(5, 1, 0);
        dart(1, 1, 0);
        chk("s2_p1", 32'(player_1_pt_o), 275);
        dart(10, 2, 0);
        chk("s2_p2", 32'(player_2_pt_o), 281);

        do_reset();
        dart(20, 3, 0); dart(20, 3, 0); dart(20, 3, 0);
        dart(0, 1, 0);  dart(22, 1, 0); dart(5, 0, 0);
        dart(20, 3, 0); dart(7, 3, 0);  dart(25, 3, 0);
        dart(0, 1, 0);  dart(0, 1, 0);  dart(0, 1, 0);
        chk("s3_start", 32'(player_1_pt_o), 40);
        dart(20, 1, 0);
        chk("s3_mid", 32'(player_1_pt_o), 20);
        dart(25, 1, 0);
        chk("s3_bust", 32'(player_1_pt_o), 40);
        dart(20, 3, 0);
        chk("s3_next", 32'(player_2_pt_o), 241);

        do_reset();
        dart(0, 1, 0);  dart(0, 1, 0);  dart(0, 1, 0);
        dart(20, 3, 0); dart(20, 3, 0); dart(20, 3, 0);
        dart(0, 1, 0);  dart(0, 1, 0);  dart(0, 1, 0);
        dart(20, 3, 0); dart(11, 1, 0); dart(0, 1, 0);
        dart(0, 1, 0);  dart(0, 1, 0);  dart(0, 1, 0);
        chk("s4_p2", 32'(player_2_pt_o), 50);
        dart(25, 2, 0);
        chk("s4_win", 32'(player_2_win_o), 1);
        chk("s4_set", 32'(game_set_o), 1);
        dart(20, 3, 0);
        chk("s4_frozen", 32'(player_1_pt_o), 301);

        do_reset();
        dart(25, 3, 1);
        chk("s5_p1", 32'(player_1_pt_o), 301);
        dart(1, 1, 0);
        dart(1, 1, 0);
        dart(2, 1, 0);
        chk("s5_turn", 32'(player_2_pt_o), 299);

        do_reset();
        dart(20, 1, 0);
        @(negedge clk);
        hit_valid_i = 1'b1;
        hit_base_i  = 5'd20;
        hit_mult_i  = 2'd3;
        @(negedge clk);
        hit_valid_i = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk_state("s6_rst");
        chk("s6_busy", 32'(busy_o), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("s6_nodone",
                32'({player_1_done_o, player_2_done_o}), 0);
        end
        dart(20, 3, 0);
        chk("s6_p1", 32'(player_1_pt_o), 241);

        for (int g = 0; g < 3; g++) begin
            do_reset();
            for (int d = 0; d < 50; d++) begin
                int b;
                int m;
                b = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 20)
                                               : $urandom_range(21, 31);
                m = $urandom_range(0, 3);
                dart(b, m, 1'($urandom_range(0, 1)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dart_game_ctrl.md
DART_GAME_CTRL -- requirements
Module: dart_game_ctrl

Interface
REQ-001 SHALL have parameter START_PT, default 301, meaning the initial points per player.
REQ-002 SHALL have parameter DARTS_PER_TURN, default 3, meaning the maximum darts per player turn.
REQ-003 SHALL have clk  input  1  system clock; all state updates occur on its rising edge.
REQ-004 SHALL have reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have hit_valid_i  input  1  one-cycle pulse: a scored dart is presented.
REQ-006 SHALL have hit_base_i  input  5  segment value: 0 (miss), 1..20, or 25 (bull).
REQ-007 SHALL have hit_mult_i  input  2  multiplier: 1..3.
REQ-008 SHALL have busy_o  output  1  high while a dart is being processed.
REQ-009 SHALL have player_1_done_o / player_2_done_o  output  1 each  one-cycle pulse when that player's dart is applied.
REQ-010 SHALL have player_1_win_o / player_2_win_o  output  1 each  held high once that player wins.
REQ-011 SHALL have player_1_pt_o / player_2_pt_o  output  9 each  remaining points.
REQ-012 SHALL have game_set_o  output  1  held high once the game has ended.

Function
REQ-013 SHALL implement the states IDLE, CALC, APPLY and OVER.
REQ-014 In IDLE, hit_valid_i=1 SHALL latch base and mult and move to CALC; busy_o SHALL be high in CALC and APPLY.
REQ-015 CALC SHALL register score = base*mult as 7 bits (maximum 60).
REQ-016 Invalid input SHALL score 0 and still count as a dart; invalid means base 21..24 or 26..31, mult 0, or base 25 with mult 3.
REQ-017 APPLY SHALL update the active player's points and pulse that player's done_o.
REQ-018 Latency: a hit_valid_i pulse at cycle N SHALL produce the done pulse and the updated points at cycle N+2.
REQ-019 APPLY SHALL return to IDLE, or go to OVER on a win.
REQ-020 hit_valid_i asserted in CALC, APPLY or OVER SHALL be ignored, with no queuing.
REQ-021 If score < remaining, remaining SHALL become remaining - score and the dart counter SHALL increment.
REQ-022 If score == remaining, points SHALL become 0, the player's win_o and game_set_o SHALL set, and the FSM SHALL enter OVER.
REQ-023 If score > remaining (bust), the player's points SHALL be restored to the turn-start value and the turn SHALL end immediately.
REQ-024 The turn SHALL end after DARTS_PER_TURN applied darts or on a bust.
REQ-025 At turn end the active player SHALL toggle, the dart counter SHALL clear, and the new player's turn-start value SHALL be captured.
REQ-026 OVER SHALL be terminal until reset; points and win flags SHALL be frozen.
REQ-027 Only one player's done_o SHALL pulse per dart, and the done pulse SHALL coincide with the bust or turn switch.

Reset
REQ-028 Reset SHALL set both points to START_PT, both turn-start values to START_PT, the FSM to IDLE, the active player to player 1, and the dart counter to 0.
REQ-029 Reset SHALL drive all done, win, busy_o and game_set_o outputs to 0.
REQ-030 Reset asserted mid-operation (CALC, APPLY or OVER) SHALL abort immediately to the reset state, and a partial dart SHALL never be applied.

Structure
REQ-031 Shared package dart_pkg SHALL hold START_PT, DARTS_PER_TURN, BULL=25, the FSM state encoding, and the score width constants.
REQ-032 Sub-module dart_hit_value SHALL contain the input validity check and the registered base*mult product used in CALC.
REQ-033 Player state SHALL be two register sets (points and turn-start) indexed by a 1-bit active-player flag.

Verification
REQ-034 Scenario: after reset, hit 20x3 -> at N+2 player_1_done_o pulses and player_1_pt_o=241, with player_2_pt_o=301.
REQ-035 Scenario: player 1 hits 20x1, 5x1, 1x1 -> player_1_pt_o=275; the next hit 10x2 is applied to player 2, giving 281.
REQ-036 Scenario: player 1 turn-start 40, hits 20x1 then 25x1 -> points 20 then bust, restored to 40; the next dart belongs to player 2.
REQ-037 Scenario: player 2 at 50 hits 25x2 -> player_2_pt_o=0, player_2_win_o=1, game_set_o=1; a further hit 20x3 changes nothing.
REQ-038 Scenario: hit 25x3 -> scores 0 and the dart counts; a second hit_valid_i pulse at N+1 is ignored (one done pulse only).
REQ-039 Scenario: reset asserted mid-turn in CALC -> both points 301, player 1 active, no done pulse.
